// File: rtl/button_event_pkg.sv
// Shared types and defaults for the button event decoder: FSM state encoding,
// default timing constants and the counter width helper.
package button_event_pkg;

    localparam int DEFAULT_LONG_CYCLES = 25_000_000;
    localparam int DEFAULT_GAP_CYCLES  = 12_500_000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        GAP    = 3'd3,
        PRESS2 = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One counter serves both windows, so it must reach the larger terminal.
    function automatic int counter_width(input int long_cycles, input int gap_cycles);
        int w;
        w = $clog2(max_int(long_cycles, gap_cycles));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Registers the previous button sample and flags rising/falling transitions.
// prev clears on reset, so a button held through reset reads as a fresh rise.
module edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    output logic rise,
    output logic fall
);

    logic prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= sample;
        end
    end

    assign rise = sample & ~prev_reg;
    assign fall = ~sample & prev_reg;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release pulses and click, double-click
// and long-press events using one FSM and one shared window counter.
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES = DEFAULT_LONG_CYCLES,
    parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic button_pressed,
    output logic press,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic held
);

    localparam int CNT_W = counter_width(LONG_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    logic             rise;
    logic             fall;
    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             press_reg;
    logic             release_reg;
    logic             single_reg;
    logic             double_reg;
    logic             long_reg;
    logic             held_reg;

    edge_detector u_edge (
        .clk    (clk),
        .reset  (reset),
        .sample (button_pressed),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            single_reg  <= 1'b0;
            double_reg  <= 1'b0;
            long_reg    <= 1'b0;
            held_reg    <= 1'b0;
        end else begin
            press_reg   <= rise;
            release_reg <= fall;
            single_reg  <= 1'b0;
            double_reg  <= 1'b0;
            long_reg    <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        state_reg <= PRESS1;
                        count_reg <= '0;
                    end
                end

                // A release on the terminal cycle still counts as a short press.
                PRESS1: begin
                    if (!button_pressed) begin
                        state_reg <= GAP;
                        count_reg <= '0;
                    end else if (count_reg == LONG_LAST) begin
                        long_reg  <= 1'b1;
                        held_reg  <= 1'b1;
                        state_reg <= LONG;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end

                LONG: begin
                    if (fall) begin
                        held_reg  <= 1'b0;
                        state_reg <= IDLE;
                        count_reg <= '0;
                    end
                end

                // A second press on the terminal cycle still counts as a double click.
                GAP: begin
                    if (rise) begin
                        double_reg <= 1'b1;
                        state_reg  <= PRESS2;
                        count_reg  <= '0;
                    end else if (count_reg == GAP_LAST) begin
                        single_reg <= 1'b1;
                        state_reg  <= IDLE;
                        count_reg  <= '0;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end

                PRESS2: begin
                    if (fall) begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

    // "release" is a reserved word, hence the suffix on that port.
    assign press         = press_reg;
    assign release_pulse = release_reg;
    assign single_click  = single_reg;
    assign double_click  = double_reg;
    assign long_press    = long_reg;
    assign held          = held_reg;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with LONG_CYCLES=8, GAP_CYCLES=5:
// stimulus pushes expected pulses with their cycle numbers, a monitor pops and compares.
module tb_button_event_decoder;
    import button_event_pkg::*;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_SINGLE  = 2;
    localparam int EV_DOUBLE  = 3;
    localparam int EV_LONG    = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic button_pressed = 1'b0;
    logic press, release_pulse, single_click, double_click, long_press, held;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    logic [4:0] mon_ev;
    logic  exp_held;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    base = 0;
    int    held_on = -1;
    int    held_off = -1;
    bit    mon_en = 1'b0;
    bit    rst_seen = 1'b0;
    string ev_name[5] = '{"press", "release", "single_click", "double_click", "long_press"};

    button_event_decoder #(
        .LONG_CYCLES (8),
        .GAP_CYCLES  (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .button_pressed (button_pressed),
        .press          (press),
        .release_pulse  (release_pulse),
        .single_click   (single_click),
        .double_click   (double_click),
        .long_press     (long_press),
        .held           (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic expect_ev(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic lvl, input int n);
        repeat (n) begin
            button_pressed = lvl;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset(input logic lvl, input int n);
        reset = 1'b1;
        button_pressed = lvl;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        total++;
        if (dut.state_reg !== IDLE) begin
            bad++;
            $display("FAIL %s: state actual=%0d required=%0d (IDLE)", tag, dut.state_reg, IDLE);
        end
    endtask

    // Monitor: every asserted pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_ev = {long_press, double_click, single_click, release_pulse, press};
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_%s: actual=none required=pulse at cycle %0d",
                         ev_name[exp_q[0].kind], exp_q[0].at);
                void'(exp_q.pop_front());
            end
            if (rst_seen) begin
                total++;
                if ({mon_ev, held} !== 6'b0) begin
                    bad++;
                    $display("FAIL reset_outputs: cycle %0d actual=%b required=000000", cyc, {mon_ev, held});
                end
            end
            for (int k = 0; k < 5; k++) begin
                if (mon_ev[k]) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_%s: actual=pulse at cycle %0d required=none", ev_name[k], cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.kind != k || mon_e.at != cyc) begin
                            bad++;
                            $display("FAIL event_%s: actual=%s at cycle %0d required=%s at cycle %0d",
                                     ev_name[k], ev_name[k], cyc, ev_name[mon_e.kind], mon_e.at);
                        end else begin
                            $display("ok %s at cycle %0d", ev_name[k], cyc);
                        end
                    end
                end
            end
            exp_held = (cyc >= held_on) && (cyc < held_off);
            total++;
            if (held !== exp_held) begin
                bad++;
                $display("FAIL held: cycle %0d actual=%b required=%b", cyc, held, exp_held);
            end
        end
    end

    initial begin
        // Reset for 3 cycles with the button already down.
        reset = 1'b1;
        button_pressed = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        base = cyc;
        expect_ev(EV_PRESS,   base + 1);
        expect_ev(EV_RELEASE, base + 3);
        expect_ev(EV_SINGLE,  base + 8);
        drive(1'b1, 2);
        drive(1'b0, 8);

        // Short press: high 3, low 10.
        base = cyc;
        expect_ev(EV_PRESS,   base + 1);
        expect_ev(EV_RELEASE, base + 4);
        expect_ev(EV_SINGLE,  base + 9);
        drive(1'b1, 3);
        drive(1'b0, 10);

        // Long press: high 12.
        base = cyc;
        held_on  = base + 9;
        held_off = base + 13;
        expect_ev(EV_PRESS,   base + 1);
        expect_ev(EV_LONG,    base + 9);
        expect_ev(EV_RELEASE, base + 13);
        drive(1'b1, 12);
        drive(1'b0, 8);

        // Double click: high 3, low 2, high 3, low.
        base = cyc;
        expect_ev(EV_PRESS,   base + 1);
        expect_ev(EV_RELEASE, base + 4);
        expect_ev(EV_PRESS,   base + 6);
        expect_ev(EV_DOUBLE,  base + 6);
        expect_ev(EV_RELEASE, base + 9);
        drive(1'b1, 3);
        drive(1'b0, 2);
        drive(1'b1, 3);
        drive(1'b0, 1);
        check_idle("idle_after_double");
        drive(1'b0, 8);

        // Fall exactly at PRESS1 counter terminal: short press, not long.
        base = cyc;
        expect_ev(EV_PRESS,   base + 1);
        expect_ev(EV_RELEASE, base + 9);
        expect_ev(EV_SINGLE,  base + 14);
        drive(1'b1, 8);
        drive(1'b0, 10);

        // Rise exactly at GAP counter terminal: double click, not single.
        base = cyc;
        expect_ev(EV_PRESS,   base + 1);
        expect_ev(EV_RELEASE, base + 4);
        expect_ev(EV_PRESS,   base + 9);
        expect_ev(EV_DOUBLE,  base + 9);
        expect_ev(EV_RELEASE, base + 11);
        drive(1'b1, 3);
        drive(1'b0, 5);
        drive(1'b1, 2);
        drive(1'b0, 10);

        // Reset in the middle of PRESS1 abandons the pending long press.
        base = cyc;
        expect_ev(EV_PRESS, base + 1);
        drive(1'b1, 4);
        apply_reset(1'b0, 2);
        check_idle("idle_after_reset_press1");
        drive(1'b0, 12);

        // Reset in the middle of GAP abandons the pending single click.
        base = cyc;
        expect_ev(EV_PRESS,   base + 1);
        expect_ev(EV_RELEASE, base + 3);
        drive(1'b1, 2);
        drive(1'b0, 2);
        apply_reset(1'b0, 2);
        check_idle("idle_after_reset_gap");
        drive(1'b0, 10);

        // Normal operation resumes after the aborted events.
        base = cyc;
        expect_ev(EV_PRESS,   base + 1);
        expect_ev(EV_RELEASE, base + 2);
        expect_ev(EV_SINGLE,  base + 7);
        drive(1'b1, 1);
        drive(1'b0, 10);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_empty: actual=%0d pending required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter LONG_CYCLES, default 25_000_000, is the hold length that gives a long press (0.5 s at 50 MHz); legal values are >= 2.
REQ-002 Parameter GAP_CYCLES, default 12_500_000, is the release window for a second press (0.25 s at 50 MHz); legal values are >= 2.
REQ-003 Port clk, input, 1 bit: single clock; all logic SHALL be rising-edge, 50 MHz nominal.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port button_pressed, input, 1 bit: debounced button level from the debounce block, already synchronous to clk.
REQ-006 Port press, output, 1 bit: one-cycle pulse on each 0->1 transition of button_pressed.
REQ-007 Port release, output, 1 bit: one-cycle pulse on each 1->0 transition of button_pressed.
REQ-008 Port single_click, output, 1 bit: one-cycle pulse when a short press is followed by no second press within the gap window.
REQ-009 Port double_click, output, 1 bit: one-cycle pulse when a second press starts inside the gap window.
REQ-010 Port long_press, output, 1 bit: one-cycle pulse when a press is held for LONG_CYCLES.
REQ-011 Port held, output, 1 bit: level that is high from long_press until release.

Function
REQ-012 A prev register SHALL hold the last sample of button_pressed; rise = sample & ~prev, fall = ~sample & prev.
REQ-013 All outputs SHALL be registered; press and release SHALL be high for exactly the cycle after the edge where rise or fall is detected (latency 1).
REQ-014 The FSM SHALL have the states IDLE, PRESS1, LONG, GAP and PRESS2, with one shared counter cleared on every state entry.
REQ-015 IDLE: on rise, go to PRESS1; otherwise stay.
REQ-016 PRESS1: if the sample is 0, go to GAP (the fall wins even at the counter terminal). If the sample is 1 and counter < LONG_CYCLES-1, increment. If the sample is 1 and counter == LONG_CYCLES-1, pulse long_press, set held, go to LONG.
REQ-017 long_press SHALL therefore be asserted exactly LONG_CYCLES cycles after the press pulse.
REQ-018 LONG: on fall, clear held and go to IDLE; no click output SHALL be generated.
REQ-019 GAP: on rise, pulse double_click in the same cycle as the press pulse and go to PRESS2. The rise wins even at the counter terminal.
REQ-020 GAP: if the sample is 0 and counter == GAP_CYCLES-1, pulse single_click, exactly GAP_CYCLES cycles after the release pulse, and go to IDLE; otherwise increment.
REQ-021 PRESS2: on fall, go to IDLE. No long_press and no further click SHALL be generated, whatever the hold length.
REQ-022 The counter width SHALL be clog2(max(LONG_CYCLES, GAP_CYCLES)); the counter SHALL never wrap, because it is bounded by the terminals.
REQ-023 press and release SHALL fire on every edge, independent of the FSM state.
REQ-024 At most one of single_click, double_click and long_press SHALL be high in any cycle.

Reset
REQ-025 While reset is sampled high, the FSM SHALL go to IDLE, and the counter, prev and all outputs SHALL be cleared to 0 on the next edge.
REQ-026 A reset mid-operation SHALL abandon the event in progress with no pulse.
REQ-027 A button held high through reset SHALL produce press on the first post-reset sample of 1, because prev resets to 0.

Structure
REQ-028 A shared package button_event_pkg SHALL hold the state enum and the default LONG_CYCLES and GAP_CYCLES constants.
REQ-029 One sub-module, edge_detector, SHALL contain prev and produce rise and fall.
REQ-030 The FSM, counter and output registers SHALL reside in button_event_decoder.

Verification (all with LONG_CYCLES=8, GAP_CYCLES=5)
REQ-031 Reset held for 3 cycles with button_pressed=1 -> all outputs 0 during reset; press pulse on the first cycle after reset release.
REQ-032 Button high 3 cycles then low 10 cycles -> press and release each fire once; single_click 5 cycles after release; no other event.
REQ-033 Button high 12 cycles -> long_press 8 cycles after press; held high until 1 cycle after the fall; release pulse; no click.
REQ-034 Button high 3, low 2, high 3, then low -> double_click in the same cycle as the second press; no single_click; FSM returns to IDLE after the second release.
REQ-035 Fall sampled exactly when the PRESS1 counter == 7 -> no long_press; single_click 5 cycles later. Rise sampled exactly when the GAP counter == 4 -> double_click, no single_click.
REQ-036 Reset asserted mid-PRESS1 and mid-GAP -> no click or long pulse; FSM in IDLE one cycle after reset.
